memory_game_ctrl: RTL and testbench

- Game-state controller for the 5x4 card-matching game (20 cards, 10 symbol pairs).
- Sits directly upstream of the card-grid painter in the 25 MHz pixel domain. It owns the deck, per-card face state, cursor, score and the mismatch reveal timer.
- The painter consumes the flattened card state, symbol and cursor buses and returns a one-cycle frame tick.

---
 rtl/memory_game_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_memory_game_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl.sv
// -----------------------------------------------------------------------------
// memory_game_ctrl
//
// Game-state controller for a 5x4 card-matching game (20 cards, 10 symbol
// pairs). Owns the deck, per-card face state, cursor, score and the mismatch
// reveal timer. Runs in the 25 MHz pixel domain next to the card-grid painter.
//
// Build option:
//   SHUFFLE_EN  - when defined, the deck is shuffled after every reset
//                 (SHUFFLE_PASSES passes of 19 LFSR-driven swap steps, busy
//                 high meanwhile). When undefined, no shuffle logic exists,
//                 the deck stays at symbol[k] = k>>1 and busy is always 0.
//
// Ports:
//   clock_25M    in   1   pixel clock, rising edge
//   reset_n      in   1   synchronous active-low reset
//   frame        in   1   one-cycle vertical-blank pulse from the painter
//   btn_up/down/left/right in 1 each  one-cycle cursor move pulses
//   btn_sel      in   1   one-cycle select pulse
//   card_state   out 40   2 bits per card: 0 HIDDEN, 1 FACE_UP, 2 MATCHED
//   card_symbol  out 80   4 bits per card, values 0..9
//   cursor_idx   out  5   row*5+col of the selected card
//   moves        out 10   compared pairs, saturating at 1023
//   pairs_found  out  4   matched pairs, 0..10
//   busy         out  1   high while shuffling
//   game_won     out  1   high once all 10 pairs are matched
// -----------------------------------------------------------------------------
module memory_game_ctrl #(
  parameter int unsigned REVEAL_FRAMES  = 30,
  parameter int unsigned SHUFFLE_PASSES = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clock_25M,
  input  logic        reset_n,
  input  logic        frame,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [39:0] card_state,
  output logic [79:0] card_symbol,
  output logic [4:0]  cursor_idx,
  output logic [9:0]  moves,
  output logic [3:0]  pairs_found,
  output logic        busy,
  output logic        game_won
);

  typedef enum logic [2:0] {
    S_SHUFFLE = 3'd0,
    S_PICK1   = 3'd1,
    S_PICK2   = 3'd2,
    S_COMPARE = 3'd3,
    S_SHOW    = 3'd4,
    S_WON     = 3'd5
  } state_e;

  localparam logic [1:0] CARD_HIDDEN  = 2'd0;
  localparam logic [1:0] CARD_FACE_UP = 2'd1;
  localparam logic [1:0] CARD_MATCHED = 2'd2;
  localparam logic [7:0] REVEAL_LAST  = 8'(REVEAL_FRAMES);

`ifdef SHUFFLE_EN
  localparam state_e     RESET_STATE = S_SHUFFLE;
  localparam logic       RESET_BUSY  = 1'b1;
  localparam logic [3:0] PASS_LAST   = 4'(SHUFFLE_PASSES - 1);
`else
  localparam state_e     RESET_STATE = S_PICK1;
  localparam logic       RESET_BUSY  = 1'b0;
`endif

  // Reject parameter values outside their legal ranges at elaboration.
  if (REVEAL_FRAMES < 1 || REVEAL_FRAMES > 255 ||
      SHUFFLE_PASSES < 1 || SHUFFLE_PASSES > 15 ||
      LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("memory_game_ctrl: illegal parameter value");
  end

  // Unshuffled deck: each symbol occupies two adjacent cards.
  function automatic logic [19:0][3:0] deck_ordered();
    logic [19:0][3:0] d;
    for (int k = 0; k < 20; k++) begin
      d[k] = 4'(k >> 1);
    end
    return d;
  endfunction

  // One wrapping cursor step on the 5x4 grid, priority up>down>left>right.
  function automatic logic [4:0] cursor_step(input logic [4:0] idx,
                                             input logic up, input logic dn,
                                             input logic lf, input logic rt);
    logic [4:0] nxt;
    logic       col0;
    logic       col4;
    col0 = (idx == 5'd0) || (idx == 5'd5) || (idx == 5'd10) || (idx == 5'd15);
    col4 = (idx == 5'd4) || (idx == 5'd9) || (idx == 5'd14) || (idx == 5'd19);
    if (up) begin
      nxt = (idx < 5'd5) ? idx + 5'd15 : idx - 5'd5;
    end else if (dn) begin
      nxt = (idx >= 5'd15) ? idx - 5'd15 : idx + 5'd5;
    end else if (lf) begin
      nxt = col0 ? idx + 5'd4 : idx - 5'd1;
    end else if (rt) begin
      nxt = col4 ? idx - 5'd4 : idx + 5'd1;
    end else begin
      nxt = idx;
    end
    return nxt;
  endfunction

  state_e           state_q, state_d;
  logic [19:0][1:0] card_q, card_d;
  logic [19:0][3:0] sym_q, sym_d;
  logic [4:0]       cursor_q, cursor_d;
  logic [9:0]       moves_q, moves_d;
  logic [3:0]       pairs_q, pairs_d;
  logic [4:0]       first_q, first_d;
  logic [4:0]       second_q, second_d;
  logic [7:0]       reveal_q, reveal_d;
  logic             busy_q, busy_d;
  logic             won_q, won_d;
  logic             any_move_s;
  logic             sel_ok_s;
  logic [7:0]       reveal_inc_s;

`ifdef SHUFFLE_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [4:0]       shuf_i_q, shuf_i_d;
  logic [3:0]       shuf_pass_q, shuf_pass_d;
  logic [4:0]       shuf_j_s;
`endif

  // Next-state logic for the game FSM, deck, cursor and score.
  always_comb begin
    state_d      = state_q;
    card_d       = card_q;
    sym_d        = sym_q;
    cursor_d     = cursor_q;
    moves_d      = moves_q;
    pairs_d      = pairs_q;
    first_d      = first_q;
    second_d     = second_q;
    reveal_d     = reveal_q;
    reveal_inc_s = reveal_q + 8'd1;
    any_move_s   = btn_up | btn_down | btn_left | btn_right;
    // A select only counts on a quiet cycle and on a card that is still hidden.
    sel_ok_s     = btn_sel & ~any_move_s & (card_q[cursor_q] == CARD_HIDDEN);
`ifdef SHUFFLE_EN
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    shuf_i_d     = shuf_i_q;
    shuf_pass_d  = shuf_pass_q;
    shuf_j_s     = lfsr_q[4:0];
`endif

    if ((state_q != S_SHUFFLE) && any_move_s) begin
      cursor_d = cursor_step(cursor_q, btn_up, btn_down, btn_left, btn_right);
    end else begin
      cursor_d = cursor_q;
    end

    case (state_q)
      S_SHUFFLE: begin
`ifdef SHUFFLE_EN
        // Draws with j > i are skipped, so the multiset is always preserved.
        if (shuf_j_s <= shuf_i_q) begin
          sym_d[shuf_i_q] = sym_q[shuf_j_s];
          sym_d[shuf_j_s] = sym_q[shuf_i_q];
        end else begin
          sym_d = sym_q;
        end
        if (shuf_i_q == 5'd1) begin
          if (shuf_pass_q == PASS_LAST) begin
            state_d = S_PICK1;
          end else begin
            shuf_pass_d = shuf_pass_q + 4'd1;
            shuf_i_d    = 5'd19;
          end
        end else begin
          shuf_i_d = shuf_i_q - 5'd1;
        end
`else
        state_d = S_PICK1;
`endif
      end
      S_PICK1: begin
        if (sel_ok_s) begin
          card_d[cursor_q] = CARD_FACE_UP;
          first_d          = cursor_q;
          state_d          = S_PICK2;
        end else begin
          state_d = S_PICK1;
        end
      end
      S_PICK2: begin
        if (sel_ok_s) begin
          card_d[cursor_q] = CARD_FACE_UP;
          second_d         = cursor_q;
          state_d          = S_COMPARE;
        end else begin
          state_d = S_PICK2;
        end
      end
      S_COMPARE: begin
        moves_d = (moves_q == 10'd1023) ? moves_q : moves_q + 10'd1;
        if (sym_q[first_q] == sym_q[second_q]) begin
          card_d[first_q]  = CARD_MATCHED;
          card_d[second_q] = CARD_MATCHED;
          pairs_d          = pairs_q + 4'd1;
          state_d          = (pairs_q == 4'd9) ? S_WON : S_PICK1;
        end else begin
          reveal_d = 8'd0;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (frame) begin
          reveal_d = reveal_inc_s;
          // Hide on the same edge the count reaches its limit.
          if (reveal_inc_s == REVEAL_LAST) begin
            card_d[first_q]  = CARD_HIDDEN;
            card_d[second_q] = CARD_HIDDEN;
            state_d          = S_PICK1;
          end else begin
            state_d = S_SHOW;
          end
        end else begin
          reveal_d = reveal_q;
        end
      end
      S_WON: begin
        state_d = S_WON;
      end
      default: begin
        state_d = S_PICK1;
      end
    endcase

    busy_d = (state_d == S_SHUFFLE);
    won_d  = (state_d == S_WON);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_25M) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      card_q      <= '0;
      sym_q       <= deck_ordered();
      cursor_q    <= 5'd0;
      moves_q     <= 10'd0;
      pairs_q     <= 4'd0;
      first_q     <= 5'd0;
      second_q    <= 5'd0;
      reveal_q    <= 8'd0;
      busy_q      <= RESET_BUSY;
      won_q       <= 1'b0;
`ifdef SHUFFLE_EN
      lfsr_q      <= LFSR_SEED;
      shuf_i_q    <= 5'd19;
      shuf_pass_q <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      card_q      <= card_d;
      sym_q       <= sym_d;
      cursor_q    <= cursor_d;
      moves_q     <= moves_d;
      pairs_q     <= pairs_d;
      first_q     <= first_d;
      second_q    <= second_d;
      reveal_q    <= reveal_d;
      busy_q      <= busy_d;
      won_q       <= won_d;
`ifdef SHUFFLE_EN
      lfsr_q      <= lfsr_d;
      shuf_i_q    <= shuf_i_d;
      shuf_pass_q <= shuf_pass_d;
`endif
    end
  end

  assign card_state  = card_q;
  assign card_symbol = sym_q;
  assign cursor_idx  = cursor_q;
  assign moves       = moves_q;
  assign pairs_found = pairs_q;
  assign busy        = busy_q;
  assign game_won    = won_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for memory_game_ctrl. A game-level reference model (cards, picks,
// row/col cursor, reveal countdown) is stepped on every clock edge and all DUT
// outputs are compared against it one time unit after the edge. Directed
// scenarios add fixed expected values; a random phase follows.
// -----------------------------------------------------------------------------
module tb_memory_game_ctrl;

  localparam int          REVEAL = 3;
  localparam int          PASSES = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  // Stimulus vector layout: {up, down, left, right, sel, frame}
  localparam logic [5:0] B_N = 6'b000000;
  localparam logic [5:0] B_U = 6'b100000;
  localparam logic [5:0] B_D = 6'b010000;
  localparam logic [5:0] B_L = 6'b001000;
  localparam logic [5:0] B_R = 6'b000100;
  localparam logic [5:0] B_S = 6'b000010;
  localparam logic [5:0] B_F = 6'b000001;

  logic        clk = 1'b0;
  logic        reset_n, frame, btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [39:0] card_state;
  logic [79:0] card_symbol;
  logic [4:0]  cursor_idx;
  logic [9:0]  moves;
  logic [3:0]  pairs_found;
  logic        busy, game_won;

  int n_total = 0;
  int n_bad   = 0;

  memory_game_ctrl #(
    .REVEAL_FRAMES (REVEAL),
    .SHUFFLE_PASSES(PASSES),
    .LFSR_SEED     (SEED)
  ) dut (
    .clock_25M  (clk),
    .reset_n    (reset_n),
    .frame      (frame),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_sel    (btn_sel),
    .card_state (card_state),
    .card_symbol(card_symbol),
    .cursor_idx (cursor_idx),
    .moves      (moves),
    .pairs_found(pairs_found),
    .busy       (busy),
    .game_won   (game_won)
  );

  always #20 clk = ~clk;

  // ---------------- reference model ----------------
  int deck0[20];
  int m_st[20];
  int m_sym[20];
  int m_row, m_col, m_moves, m_pairs, m_reveal, m_busy;
  bit m_won, m_cmp, m_show;
  int picks[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic build_deck();
    logic [15:0] l;
    int          j, t;
    for (int k = 0; k < 20; k++) deck0[k] = k / 2;
`ifdef SHUFFLE_EN
    l = SEED;
    for (int p = 0; p < PASSES; p++) begin
      for (int i = 19; i >= 1; i--) begin
        j = int'(l[4:0]);
        if (j <= i) begin
          t = deck0[i]; deck0[i] = deck0[j]; deck0[j] = t;
        end
        l = lfsr_next(l);
      end
    end
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 20; k++) begin
      m_st[k]  = 0;
      m_sym[k] = deck0[k];
    end
    m_row = 0; m_col = 0; m_moves = 0; m_pairs = 0; m_reveal = 0;
    m_won = 0; m_cmp = 0; m_show = 0;
    picks.delete();
`ifdef SHUFFLE_EN
    m_busy = 19 * PASSES;
`else
    m_busy = 0;
`endif
  endtask

  task automatic model_step(input logic [5:0] b, input logic rst);
    bit moved, sel_ok;
    int cur, a, c;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    moved  = b[5] | b[4] | b[3] | b[2];
    cur    = m_row * 5 + m_col;
    sel_ok = b[1] && !moved && !m_won && !m_cmp && !m_show && (m_st[cur] == 0);
    if (b[5])      m_row = (m_row + 3) % 4;
    else if (b[4]) m_row = (m_row + 1) % 4;
    else if (b[3]) m_col = (m_col + 4) % 5;
    else if (b[2]) m_col = (m_col + 1) % 5;
    if (m_cmp) begin
      m_cmp = 0;
      if (m_moves < 1023) m_moves++;
      a = picks[0];
      c = picks[1];
      if (m_sym[a] == m_sym[c]) begin
        m_st[a] = 2; m_st[c] = 2;
        m_pairs++;
        if (m_pairs == 10) m_won = 1;
        picks.delete();
      end else begin
        m_show   = 1;
        m_reveal = REVEAL;
      end
    end else if (m_show) begin
      if (b[0]) begin
        m_reveal--;
        if (m_reveal == 0) begin
          m_st[picks[0]] = 0; m_st[picks[1]] = 0;
          picks.delete();
          m_show = 0;
        end
      end
    end else if (sel_ok) begin
      m_st[cur] = 1;
      picks.push_back(cur);
      if (picks.size() == 2) m_cmp = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [39:0] es;
    logic [79:0] ey;
    for (int k = 0; k < 20; k++) begin
      es[2*k +: 2] = 2'(m_st[k]);
      ey[4*k +: 4] = 4'(m_sym[k]);
    end
    check_eq("card_state", 80'(card_state), 80'(es));
    if (m_busy == 0) check_eq("card_symbol", card_symbol, ey);
    check_eq("cursor", 80'(cursor_idx), 80'(m_row * 5 + m_col));
    check_eq("moves", 80'(moves), 80'(m_moves));
    check_eq("pairs", 80'(pairs_found), 80'(m_pairs));
    check_eq("busy", 80'(busy), 80'(m_busy > 0));
    check_eq("won", 80'(game_won), 80'(m_won));
  endtask

  task automatic tick(input logic [5:0] b, input logic rst);
    {btn_up, btn_down, btn_left, btn_right, btn_sel, frame} = b;
    reset_n = rst;
    @(posedge clk);
    model_step(b, rst);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    int cnt;
    tick(B_N, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      tick(B_N, 1'b1);
      cnt++;
    end
`ifdef SHUFFLE_EN
    check_eq("busy_cycles", 80'(cnt), 80'(19 * PASSES));
`else
    check_eq("busy_cycles", 80'(cnt), 80'(0));
`endif
  endtask

  task automatic goto_card(input int k);
    for (int n = 0; n < 10 && (m_row * 5 + m_col) != k; n++) begin
      if (m_col != k % 5) tick(B_R, 1'b1);
      else                tick(B_D, 1'b1);
    end
  endtask

  initial begin
    int a, c;
    logic [5:0] b;
    logic       rst;
    {btn_up, btn_down, btn_left, btn_right, btn_sel, frame} = B_N;
    reset_n = 1'b0;
    build_deck();

    // First pair: select 0, move right, select 1, compare.
    do_reset();
    check_eq("rst_moves", 80'(moves), 80'(0));
    check_eq("rst_cursor", 80'(cursor_idx), 80'(0));
    tick(B_S, 1'b1); tick(B_R, 1'b1); tick(B_S, 1'b1); tick(B_N, 1'b1);
`ifndef SHUFFLE_EN
    check_eq("pair_state", 80'(card_state), 80'(40'hA));
    check_eq("pair_pairs", 80'(pairs_found), 80'(1));
    check_eq("pair_moves", 80'(moves), 80'(1));
    // Select on an already matched card does nothing.
    goto_card(0); tick(B_S, 1'b1); tick(B_N, 1'b1);
    check_eq("sel_matched", 80'(card_state), 80'(40'hA));
    check_eq("sel_matched_moves", 80'(moves), 80'(1));
`endif

    // Mismatch with reveal timer.
    do_reset();
    tick(B_S, 1'b1); goto_card(2); tick(B_S, 1'b1); tick(B_N, 1'b1);
`ifndef SHUFFLE_EN
    check_eq("mis_faceup", 80'(card_state), 80'(40'h11));
    check_eq("mis_moves", 80'(moves), 80'(1));
`endif
    tick(B_F, 1'b1); tick(B_F, 1'b1);
`ifndef SHUFFLE_EN
    check_eq("mis_still_up", 80'(card_state), 80'(40'h11));
`endif
    tick(B_F, 1'b1);
    check_eq("mis_hidden", 80'(card_state), 80'(0));

    // Reset in the middle of the reveal phase.
    do_reset();
    tick(B_S, 1'b1); goto_card(2); tick(B_S, 1'b1); tick(B_N, 1'b1); tick(B_F, 1'b1);
    tick(B_N, 1'b0);
    check_eq("rst_show_state", 80'(card_state), 80'(0));
    check_eq("rst_show_moves", 80'(moves), 80'(0));
    check_eq("rst_show_cursor", 80'(cursor_idx), 80'(0));
`ifndef SHUFFLE_EN
    tick(B_S, 1'b1);
    check_eq("rst_show_pick1", 80'(card_state), 80'(40'h1));
`endif

    // Cursor wrap and select-with-move rule.
    do_reset();
    tick(B_L, 1'b1);
    check_eq("wrap_left", 80'(cursor_idx), 80'(4));
    tick(B_U, 1'b1);
    check_eq("wrap_up", 80'(cursor_idx), 80'(19));
    tick(B_D, 1'b1);
    check_eq("wrap_down", 80'(cursor_idx), 80'(4));
    tick(B_S | B_R, 1'b1);
    check_eq("selmove_cursor", 80'(cursor_idx), 80'(0));
    check_eq("selmove_state", 80'(card_state), 80'(0));

    // Win: match every pair, then a further select changes nothing.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      a = -1; c = -1;
      for (int k = 0; k < 20; k++) begin
        if (m_sym[k] == s) begin
          if (a < 0) a = k;
          else       c = k;
        end
      end
      goto_card(a); tick(B_S, 1'b1);
      goto_card(c); tick(B_S, 1'b1);
      tick(B_N, 1'b1);
    end
    check_eq("win_flag", 80'(game_won), 80'(1));
    check_eq("win_pairs", 80'(pairs_found), 80'(10));
    check_eq("win_moves", 80'(moves), 80'(10));
    check_eq("win_state", 80'(card_state), 80'(40'hAAAAAAAAAA));
    goto_card(3); tick(B_S, 1'b1); tick(B_N, 1'b1);
    check_eq("win_hold_state", 80'(card_state), 80'(40'hAAAAAAAAAA));
    check_eq("win_hold_moves", 80'(moves), 80'(10));
    check_eq("win_hold_flag", 80'(game_won), 80'(1));

    // Random play with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      b = B_N;
      case ($urandom_range(0, 9))
        0: b = b | B_U;
        1: b = b | B_D;
        2: b = b | B_L;
        3: b = b | B_R;
        default: b = b | B_N;
      endcase
      if ($urandom_range(0, 2) == 0) b = b | B_S;
      if ($urandom_range(0, 2) == 0) b = b | B_F;
      rst = ($urandom_range(0, 499) != 0);
      tick(b, rst);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
